// File: rtl/tea_pkg.sv
// Shared TEA/XTEA constants, state/encoding types and round-mix helpers.
package tea_pkg;

    localparam logic [31:0] DELTA = 32'h9E37_79B9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;
    localparam logic ALG_TEA  = 1'b0;
    localparam logic ALG_XTEA = 1'b1;

    typedef logic [127:0] key_t;
    typedef logic [63:0]  blk_t;

    function automatic logic [31:0] tea_mix(
        input logic [31:0] v,
        input logic [31:0] s,
        input logic [31:0] ka,
        input logic [31:0] kb
    );
        return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
    endfunction

    function automatic logic [31:0] xtea_mix(input logic [31:0] v);
        return ((v << 4) ^ (v >> 5)) + v;
    endfunction

    // k0 is the most significant word of the key
    function automatic logic [31:0] key_word(
        input key_t       k,
        input logic [1:0] i
    );
        return k[32 * (3 - int'(i)) +: 32];
    endfunction

endpackage

// File: rtl/tea_cycle.sv
// One full TEA/XTEA cycle (both half-rounds), purely combinational.
module tea_cycle
    import tea_pkg::*;
(
    input  logic [63:0]  v,
    input  logic [127:0] key,
    input  logic [31:0]  sum,
    input  logic         mode,
    input  logic         alg,
    output logic [63:0]  v_next
);

    logic [31:0] v0, v1, n0, n1, sum_nx;

    always_comb begin
        v0     = v[63:32];
        v1     = v[31:0];
        n0     = v0;
        n1     = v1;
        sum_nx = (mode == MODE_DEC) ? sum - DELTA : sum + DELTA;
        unique case ({alg, mode})
            {ALG_TEA, MODE_ENC}: begin
                n0 = v0 + tea_mix(v1, sum, key_word(key, 2'd0), key_word(key, 2'd1));
                n1 = v1 + tea_mix(n0, sum, key_word(key, 2'd2), key_word(key, 2'd3));
            end
            {ALG_TEA, MODE_DEC}: begin
                n1 = v1 - tea_mix(v0, sum, key_word(key, 2'd2), key_word(key, 2'd3));
                n0 = v0 - tea_mix(n1, sum, key_word(key, 2'd0), key_word(key, 2'd1));
            end
            // XTEA steps sum between the halves, so the second half sees sum_nx
            {ALG_XTEA, MODE_ENC}: begin
                n0 = v0 + (xtea_mix(v1) ^ (sum + key_word(key, sum[1:0])));
                n1 = v1 + (xtea_mix(n0) ^ (sum_nx + key_word(key, sum_nx[12:11])));
            end
            {ALG_XTEA, MODE_DEC}: begin
                n1 = v1 - (xtea_mix(v0) ^ (sum + key_word(key, sum[12:11])));
                n0 = v0 - (xtea_mix(n1) ^ (sum_nx + key_word(key, sum_nx[1:0])));
            end
            default: ;
        endcase
        v_next = {n0, n1};
    end

endmodule

// File: rtl/tea_stream_core.sv
// Streaming TEA/XTEA block core; one cycle per clock, ROUNDS+1 latency.
// Optional CBC chaining is enabled by defining TEA_CBC_EN.
module tea_stream_core
    import tea_pkg::*;
#(
    parameter int ROUNDS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] key_in,
    input  logic        key_wr,
    input  logic        key_sel,
`ifdef TEA_CBC_EN
    input  logic        iv_wr,
    input  logic        in_chain,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_mode,
    input  logic        in_alg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    localparam logic [5:0]  LAST    = 6'(ROUNDS - 1);
    localparam logic [31:0] SUM_DEC = 32'(ROUNDS) * DELTA;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] sum_q, sum_d;
    blk_t        v_q, v_d, od_q, od_d;
    key_t        key_q, key_d;
    logic        mode_q, mode_d, alg_q, alg_d, ov_q, ov_d;
    logic        key_en, accept;
    blk_t        v_next, xin, omask;

    tea_cycle u_cycle (
        .v      (v_q),
        .key    (key_q),
        .sum    (sum_q),
        .mode   (mode_q),
        .alg    (alg_q),
        .v_next (v_next)
    );

`ifdef TEA_CBC_EN
    blk_t chain_q, chain_d, mask_q, mask_d;
    logic cenc_q, cenc_d;

    assign in_ready = (state_q == IDLE) && !key_wr && !iv_wr;
    assign key_en   = (state_q == IDLE) && key_wr && !iv_wr;
    assign xin      = (in_chain && in_mode == MODE_ENC) ? in_data ^ chain_q : in_data;
    assign omask    = mask_q;

    // Decrypt keeps the old chain as an output mask; encrypt chains on its result
    always_comb begin
        chain_d = chain_q;
        mask_d  = mask_q;
        cenc_d  = cenc_q;
        if (state_q == IDLE && iv_wr) chain_d = key_in;
        if (accept) begin
            cenc_d = in_chain && in_mode == MODE_ENC;
            mask_d = (in_chain && in_mode == MODE_DEC) ? chain_q : '0;
            if (in_chain && in_mode == MODE_DEC) chain_d = in_data;
        end
        if (state_q == DONE && !ov_q && cenc_q) chain_d = v_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
            mask_q  <= '0;
            cenc_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            mask_q  <= mask_d;
            cenc_q  <= cenc_d;
        end
    end
`else
    assign in_ready = (state_q == IDLE) && !key_wr;
    assign key_en   = (state_q == IDLE) && key_wr;
    assign xin      = in_data;
    assign omask    = '0;
`endif

    assign accept    = in_valid && in_ready;
    assign busy      = state_q != IDLE;
    assign out_valid = ov_q;
    assign out_data  = od_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        v_d     = v_q;
        mode_d  = mode_q;
        alg_d   = alg_q;
        key_d   = key_q;
        ov_d    = ov_q;
        od_d    = od_q;
        if (key_en) begin
            if (key_sel) key_d[127:64] = key_in;
            else         key_d[63:0]   = key_in;
        end
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    v_d     = xin;
                    mode_d  = in_mode;
                    alg_d   = in_alg;
                    if (in_mode == MODE_DEC)     sum_d = SUM_DEC;
                    else if (in_alg == ALG_TEA)  sum_d = DELTA;
                    else                         sum_d = '0;
                end
            end
            RUN: begin
                v_d   = v_next;
                sum_d = (mode_q == MODE_DEC) ? sum_q - DELTA : sum_q + DELTA;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST) state_d = DONE;
            end
            // First DONE cycle registers the result, giving ROUNDS+1 latency
            DONE: begin
                if (!ov_q) begin
                    ov_d = 1'b1;
                    od_d = v_q ^ omask;
                end else if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            v_q     <= '0;
            mode_q  <= 1'b0;
            alg_q   <= 1'b0;
            key_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            v_q     <= v_d;
            mode_q  <= mode_d;
            alg_q   <= alg_d;
            key_q   <= key_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
        end
    end

endmodule
